// File: rtl/alu_arbiter.sv
// Round-robin arbiter granting two requesters turns on one shared combinational ALU.
// Optional macro ALU_ARBITER_ERRCNT_EN adds an 8-bit saturating count of erroring responses.
module alu_arbiter #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic [3:0]  req0_cmd,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   input  logic [3:0]  req1_cmd,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_cmd,
   input  logic [31:0] alu_result,
   input  logic [1:0]  alu_error,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic [1:0]  rsp_error,
   output logic        busy
`ifdef ALU_ARBITER_ERRCNT_EN
   ,
   output logic [7:0]  err_count
`endif
);

   typedef enum logic [1:0] {IDLE, SETTLE, RESPOND} state_t;

   state_t      state, state_nx;
   logic        last_grant;
   logic        win;
   logic        accept, capture, done;
   logic [3:0]  cnt;
   logic [15:0] op_a, op_b;
   logic [3:0]  op_cmd;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      done       = 1'b0;
      rsp_valid  = 1'b0;
      busy       = 1'b1;
      // on a tie the requester that did not win last time goes next
      win        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if ((req0_valid || req1_valid) && !rst) begin
               accept     = 1'b1;
               req0_ready = ~win;
               req1_ready = win;
               state_nx   = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == 4'd0) begin
               capture  = 1'b1;
               state_nx = RESPOND;
            end
         end
         RESPOND: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         cnt        <= 4'd0;
         op_a       <= 16'd0;
         op_b       <= 16'd0;
         op_cmd     <= 4'd0;
         rsp_id     <= 1'b0;
         rsp_result <= 32'd0;
         rsp_error  <= 2'd0;
      end else begin
         if (accept) begin
            op_a   <= win ? req1_a   : req0_a;
            op_b   <= win ? req1_b   : req0_b;
            op_cmd <= win ? req1_cmd : req0_cmd;
            rsp_id <= win;
            cnt    <= 4'(SETTLE_CYCLES - 1);
         end else if (state == SETTLE && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) begin
            rsp_result <= alu_result;
            rsp_error  <= alu_error;
         end
         if (done) last_grant <= rsp_id;
      end
   end

   assign alu_a   = (state == SETTLE) ? op_a   : 16'd0;
   assign alu_b   = (state == SETTLE) ? op_b   : 16'd0;
   assign alu_cmd = (state == SETTLE) ? op_cmd : 4'd0;

`ifdef ALU_ARBITER_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         err_count <= 8'd0;
      else if (done && rsp_error != 2'd0 && err_count != 8'hFF)
         err_count <= err_count + 8'd1;
   end
`endif

endmodule
